// File: rtl/adding_machine_pkg.sv
// Shared widths, opcode encodings and instruction field helpers for the adding machine.
package adding_machine_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;

  function automatic logic [2:0] opcode_field(input logic [DATA_W-1:0] instr);
    return instr[DATA_W-1 -: 3];
  endfunction

  function automatic logic [ADDR_W-1:0] operand_field(input logic [DATA_W-1:0] instr);
    return instr[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/adding_machine_alu.sv
// Combinational add/pass unit: adds the bus to ACC or passes the bus straight through.
module adding_machine_alu
  import adding_machine_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] bus_i,
  input  logic         pass_add_i,
  output logic [W-1:0] result_o,
  output logic         carry_o
);

  logic [W:0] sum;

  always_comb begin
    sum = {1'b0, acc_i} + {1'b0, bus_i};
    if (pass_add_i) begin
      result_o = sum[W-1:0];
      carry_o  = sum[W];
    end else begin
      result_o = bus_i;
      carry_o  = 1'b0;
    end
  end

endmodule

// File: rtl/adding_machine_datapath.sv
// Datapath for the adding machine: PC, IR, ACC, flags and memory address/data muxing,
// driven cycle by cycle by the controller's strobes.
module adding_machine_datapath #(
  parameter int DATA_W = adding_machine_pkg::DATA_W,
  parameter int ADDR_W = adding_machine_pkg::ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_IR,
  input  logic              load_acc,
  input  logic              ld_pc,
  input  logic              clr_pc,
  input  logic              inc_pc,
  input  logic              sel_alu,
  input  logic              sel_bus,
  input  logic              pass_add,
  input  logic              ir_on_adr,
  input  logic              pc_on_adr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        opcode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic              carry,
  output logic              zero,
  output logic              ctrl_error,
  output logic [CNT_W-1:0]  instr_count
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              acc_wr_ok;
  logic              err_set;

  adding_machine_alu #(.W(DATA_W)) u_alu (
    .acc_i      (acc_q),
    .bus_i      (mem_rdata),
    .pass_add_i (pass_add),
    .result_o   (alu_result),
    .carry_o    (alu_carry)
  );

  // Exactly one ACC source must be selected; anything else is a controller bug and holds ACC.
  assign acc_wr_ok = load_acc & (sel_alu ^ sel_bus);

  assign err_set = (pc_on_adr & ir_on_adr)
                 | (load_acc & ~(sel_alu ^ sel_bus))
                 | (mem_read & mem_write)
                 | (mem_write & load_acc);

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    err_d   = err_q | err_set;

    // Fetch asserts ld_pc together with inc_pc; increment must win.
    if (clr_pc)      pc_d = '0;
    else if (inc_pc) pc_d = pc_q + ADDR_W'(1);
    else if (ld_pc)  pc_d = ir_q[ADDR_W-1:0];

    if (load_IR) begin
      ir_d  = mem_rdata;
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (acc_wr_ok) begin
      if (sel_alu) begin
        acc_d   = alu_result;
        carry_d = alu_carry;
      end else begin
        acc_d   = mem_rdata;
        carry_d = 1'b0;
      end
      zero_d = (acc_d == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    mem_addr = '0;
    if (pc_on_adr)      mem_addr = pc_q;
    else if (ir_on_adr) mem_addr = ir_q[ADDR_W-1:0];
  end

  // Write data is the pre-edge ACC, so a coinciding ACC load never leaks into the store.
  assign mem_wdata   = acc_q;
  assign mem_we      = mem_write;
  assign mem_re      = mem_read | load_IR;
  assign opcode      = ir_q[DATA_W-1 -: 3];
  assign acc         = acc_q;
  assign pc          = pc_q;
  assign carry       = carry_q;
  assign zero        = zero_q;
  assign ctrl_error  = err_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_adding_machine_datapath.sv
// Directed bench for adding_machine_datapath: a vector table plus error/reset sequences.
module tb_adding_machine_datapath;
  import adding_machine_pkg::*;

  logic        clock;
  logic        reset;
  logic        load_IR, load_acc, ld_pc, clr_pc, inc_pc;
  logic        sel_alu, sel_bus, pass_add, ir_on_adr, pc_on_adr;
  logic        mem_read, mem_write;
  logic [7:0]  mem_rdata;
  logic [2:0]  opcode;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re;
  logic [7:0]  acc;
  logic [4:0]  pc;
  logic        carry, zero, ctrl_error;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  adding_machine_datapath dut (
    .clock       (clock),
    .reset       (reset),
    .load_IR     (load_IR),
    .load_acc    (load_acc),
    .ld_pc       (ld_pc),
    .clr_pc      (clr_pc),
    .inc_pc      (inc_pc),
    .sel_alu     (sel_alu),
    .sel_bus     (sel_bus),
    .pass_add    (pass_add),
    .ir_on_adr   (ir_on_adr),
    .pc_on_adr   (pc_on_adr),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_rdata   (mem_rdata),
    .opcode      (opcode),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .acc         (acc),
    .pc          (pc),
    .carry       (carry),
    .zero        (zero),
    .ctrl_error  (ctrl_error),
    .instr_count (instr_count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Control strobe bit positions in a packed control word.
  localparam logic [11:0] C_LIR  = 12'h001;
  localparam logic [11:0] C_LACC = 12'h002;
  localparam logic [11:0] C_LDPC = 12'h004;
  localparam logic [11:0] C_CLR  = 12'h008;
  localparam logic [11:0] C_INC  = 12'h010;
  localparam logic [11:0] C_ALU  = 12'h020;
  localparam logic [11:0] C_BUS  = 12'h040;
  localparam logic [11:0] C_ADD  = 12'h080;
  localparam logic [11:0] C_IRA  = 12'h100;
  localparam logic [11:0] C_PCA  = 12'h200;
  localparam logic [11:0] C_RD   = 12'h400;
  localparam logic [11:0] C_WR   = 12'h800;

  typedef struct {
    logic [11:0] ctrl;
    logic [7:0]  rdata;
    logic [4:0]  exp_addr;
    logic [4:0]  exp_pc;
    logic [7:0]  exp_acc;
    logic        exp_carry;
    logic        exp_zero;
    logic [2:0]  exp_op;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] acc_model;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [11:0] c, input logic [7:0] rd);
    load_IR   = c[0];
    load_acc  = c[1];
    ld_pc     = c[2];
    clr_pc    = c[3];
    inc_pc    = c[4];
    sel_alu   = c[5];
    sel_bus   = c[6];
    pass_add  = c[7];
    ir_on_adr = c[8];
    pc_on_adr = c[9];
    mem_read  = c[10];
    mem_write = c[11];
    mem_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"},    32'(pc), 32'h0);
    chk({tag, "_acc"},   32'(acc), 32'h0);
    chk({tag, "_carry"}, 32'(carry), 32'h0);
    chk({tag, "_zero"},  32'(zero), 32'h1);
    chk({tag, "_err"},   32'(ctrl_error), 32'h0);
    chk({tag, "_cnt"},   32'(instr_count), 32'h0);
    chk({tag, "_op"},    32'(opcode), 32'h0);
  endtask

  task automatic add_vec(input logic [11:0] c, input logic [7:0] rd, input logic [4:0] a,
                         input logic [4:0] p, input logic [7:0] ac, input logic cy,
                         input logic z, input logic [2:0] op, input logic [15:0] cnt);
    vec_t v;
    v.ctrl = c; v.rdata = rd; v.exp_addr = a; v.exp_pc = p; v.exp_acc = ac;
    v.exp_carry = cy; v.exp_zero = z; v.exp_op = op; v.exp_cnt = cnt;
    vecs.push_back(v);
  endtask

  // ---------------- stimulus and checking ----------------
  initial begin
    drive(12'h000, 8'h00);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk_reset_state("reset");
    chk("reset_addr", 32'(mem_addr), 32'h0);
    chk("reset_re",   32'(mem_re), 32'h0);
    chk("reset_we",   32'(mem_we), 32'h0);

    //       ctrl                              rdata  addr   pc     acc    c  z  op        cnt
    add_vec(C_CLR,                             8'h00, 5'h00, 5'h00, 8'h00, 0, 1, 3'b000,   0);
    add_vec(C_LDPC|C_INC|C_PCA,                8'h00, 5'h00, 5'h01, 8'h00, 0, 1, 3'b000,   0);
    add_vec(C_LDPC|C_INC|C_PCA,                8'h00, 5'h01, 5'h02, 8'h00, 0, 1, 3'b000,   0);
    add_vec(C_LDPC|C_INC|C_PCA,                8'h00, 5'h02, 5'h03, 8'h00, 0, 1, 3'b000,   0);
    add_vec(C_LIR|C_PCA|C_RD|C_INC,            8'h25, 5'h03, 5'h04, 8'h00, 0, 1, OP_LOAD,  1);
    add_vec(C_LACC|C_BUS|C_IRA|C_RD,           8'h7F, 5'h05, 5'h04, 8'h7F, 0, 0, OP_LOAD,  1);
    add_vec(C_LACC|C_BUS,                      8'hF0, 5'h00, 5'h04, 8'hF0, 0, 0, OP_LOAD,  1);
    add_vec(C_LACC|C_ALU|C_ADD,                8'h20, 5'h00, 5'h04, 8'h10, 1, 0, OP_LOAD,  1);
    add_vec(C_LACC|C_ALU|C_ADD,                8'hF0, 5'h00, 5'h04, 8'h00, 1, 1, OP_LOAD,  1);
    add_vec(C_LACC|C_ALU,                      8'h5A, 5'h00, 5'h04, 8'h5A, 0, 0, OP_LOAD,  1);
    add_vec(C_LIR,                             8'h5F, 5'h00, 5'h04, 8'h5A, 0, 0, OP_STORE, 2);
    add_vec(C_WR|C_IRA,                        8'h00, 5'h1F, 5'h04, 8'h5A, 0, 0, OP_STORE, 2);
    add_vec(C_LDPC,                            8'h00, 5'h00, 5'h1F, 8'h5A, 0, 0, OP_STORE, 2);
    add_vec(C_INC,                             8'h00, 5'h00, 5'h00, 8'h5A, 0, 0, OP_STORE, 2);
    add_vec(C_LIR,                             8'h2C, 5'h00, 5'h00, 8'h5A, 0, 0, OP_LOAD,  3);
    add_vec(C_LDPC,                            8'h00, 5'h00, 5'h0C, 8'h5A, 0, 0, OP_LOAD,  3);
    add_vec(C_CLR|C_INC,                       8'h00, 5'h00, 5'h00, 8'h5A, 0, 0, OP_LOAD,  3);
    add_vec(C_LACC|C_BUS|C_ADD,                8'h00, 5'h00, 5'h00, 8'h00, 0, 1, OP_LOAD,  3);

    acc_model = 8'h00;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ctrl, vecs[i].rdata);
      #1;
      chk($sformatf("v%0d_addr", i),  32'(mem_addr), 32'(vecs[i].exp_addr));
      chk($sformatf("v%0d_wdata", i), 32'(mem_wdata), 32'(acc_model));
      chk($sformatf("v%0d_we", i),    32'(mem_we), 32'(vecs[i].ctrl[11]));
      chk($sformatf("v%0d_re", i),    32'(mem_re), 32'(vecs[i].ctrl[10] | vecs[i].ctrl[0]));
      tick();
      chk($sformatf("v%0d_pc", i),    32'(pc), 32'(vecs[i].exp_pc));
      chk($sformatf("v%0d_acc", i),   32'(acc), 32'(vecs[i].exp_acc));
      chk($sformatf("v%0d_carry", i), 32'(carry), 32'(vecs[i].exp_carry));
      chk($sformatf("v%0d_zero", i),  32'(zero), 32'(vecs[i].exp_zero));
      chk($sformatf("v%0d_op", i),    32'(opcode), 32'(vecs[i].exp_op));
      chk($sformatf("v%0d_cnt", i),   32'(instr_count), 32'(vecs[i].exp_cnt));
      chk($sformatf("v%0d_err", i),   32'(ctrl_error), 32'h0);
      acc_model = vecs[i].exp_acc;
    end

    // Both address sources: PC wins and the sticky error sets.
    drive(C_PCA|C_IRA, 8'h00);
    #1;
    chk("both_adr_addr", 32'(mem_addr), 32'h00);
    tick();
    chk("both_adr_err", 32'(ctrl_error), 32'h1);
    drive(12'h000, 8'h00);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("sticky%0d_err", i), 32'(ctrl_error), 32'h1);
    end

    // Illegal ACC source selections hold ACC and flags.
    drive(C_LACC|C_ALU|C_BUS|C_ADD, 8'h33);
    tick();
    chk("both_sel_acc",  32'(acc), 32'h00);
    chk("both_sel_zero", 32'(zero), 32'h1);
    drive(C_LACC, 8'h44);
    tick();
    chk("no_sel_acc", 32'(acc), 32'h00);

    // Reset mid-instruction overrides every strobe.
    drive(C_LIR|C_LACC|C_BUS|C_INC, 8'hFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(12'h000, 8'h00);
    #1;
    chk_reset_state("midreset");

    // Store coinciding with an ACC load writes the old ACC.
    drive(C_LACC|C_BUS, 8'h5A);
    tick();
    chk("pre_store_err", 32'(ctrl_error), 32'h0);
    drive(C_LACC|C_BUS|C_WR, 8'h11);
    #1;
    chk("store_old_wdata", 32'(mem_wdata), 32'h5A);
    chk("store_old_we",    32'(mem_we), 32'h1);
    tick();
    chk("store_old_acc", 32'(acc), 32'h11);
    chk("store_old_err", 32'(ctrl_error), 32'h1);

    // Read and write together also flag an error.
    drive(12'h000, 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rdwr_pre_err", 32'(ctrl_error), 32'h0);
    drive(C_RD|C_WR, 8'h00);
    tick();
    chk("rdwr_err", 32'(ctrl_error), 32'h1);
    chk("rdwr_acc", 32'(acc), 32'h00);
    drive(12'h000, 8'h00);
    tick();

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adding_machine_datapath.md
Name: adding_machine_datapath

Overview:
Datapath end of the adding-machine control interface. It consumes the per-cycle control strobes from the controller FSM and holds PC, IR, ACC and flags. It drives the external memory address and data and returns the IR opcode field to the controller. Memory read is combinational: mem_rdata is valid in the same cycle as mem_addr.

Parameters:
DATA_W, 8, word width; instruction = opcode[DATA_W-1 -: 3] and operand[ADDR_W-1:0]
ADDR_W, 5, address width; must satisfy ADDR_W <= DATA_W-3
CNT_W, 16, width of the retired-instruction counter

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
load_IR  in  1  IR <= mem_rdata
load_acc  in  1  ACC write enable
ld_pc  in  1  PC <= IR operand
clr_pc  in  1  PC <= 0
inc_pc  in  1  PC <= PC+1
sel_alu  in  1  ACC source = ALU result
sel_bus  in  1  ACC source = mem_rdata
pass_add  in  1  ALU adds (1) or passes bus (0)
ir_on_adr  in  1  mem_addr = IR operand
pc_on_adr  in  1  mem_addr = PC
mem_read  in  1  data read request
mem_write  in  1  data write request
mem_rdata  in  DATA_W  memory read data
opcode  out  3  IR[DATA_W-1 -: 3]
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  always ACC
mem_we  out  1  = mem_write (combinational)
mem_re  out  1  = mem_read | load_IR
acc  out  DATA_W  accumulator
pc  out  ADDR_W  program counter
carry  out  1  carry from last add
zero  out  1  ACC == 0 after last ACC write
ctrl_error  out  1  sticky illegal-strobe flag
instr_count  out  CNT_W  number of IR loads

Behaviour:
- Reset (synchronous, highest priority) sets PC=0, IR=0, ACC=0, carry=0, zero=1, ctrl_error=0, instr_count=0. Combinational outputs follow from these register values.
- Address mux:
  - pc_on_adr only -> PC.
  - ir_on_adr only -> IR[ADDR_W-1:0].
  - Both -> PC, and ctrl_error is set.
  - Neither -> 0.
- PC update, priority clr_pc > inc_pc > ld_pc:
  - ld_pc together with inc_pc increments (this is the fetch case) and is legal.
  - Increment wraps from 2^ADDR_W-1 to 0.
  - The new PC is visible on the next cycle.
- IR: load_IR loads mem_rdata at the clock edge. opcode is taken from the registered IR, so it is valid one cycle after load_IR. instr_count increments on every load_IR and wraps modulo 2^CNT_W.
- ALU (combinational):
  - pass_add=1: sum = ACC + mem_rdata, width DATA_W+1. The result is sum[DATA_W-1:0]; carry-out is sum[DATA_W].
  - pass_add=0: result = mem_rdata, carry-out = 0.
- ACC write on load_acc:
  - sel_alu only: ACC <= ALU result; carry <= carry-out.
  - sel_bus only: ACC <= mem_rdata; carry <= 0.
  - Both set or neither set: ACC and carry hold, and ctrl_error is set.
  - On any successful write, zero <= (new ACC == 0). Otherwise flags hold.
- Memory:
  - mem_we and mem_re are pure pass-through; there is no wait state.
  - A write commits ACC as it was before the edge. When load_acc and mem_write coincide, the old ACC is written.
- ctrl_error additionally sets on mem_read & mem_write, and on mem_write & load_acc.
  - It is sticky until reset.
  - It is informational only and blocks nothing except the ACC hold case above.
- Reset asserted mid-instruction overrides all strobes in that cycle.

Decomposition:
- Package adding_machine_pkg:
  - Width constants DATA_W, ADDR_W.
  - Opcode constants OP_ADD=3'b000, OP_LOAD=3'b001, OP_STORE=3'b010.
  - Functions for the opcode and operand field slices.
- Sub-module adding_machine_alu: combinational adder/pass unit producing result and carry-out.
- Registers, muxes and error logic stay in the top module.

Test Plan:
1. Reset, then clr_pc; then 3 cycles of ld_pc+inc_pc+pc_on_adr -> pc = 1, 2, 3; mem_addr equals pc of the prior cycle; ctrl_error = 0.
2. mem_rdata=8'h25, load_IR -> next cycle opcode=3'b001 and ir_on_adr gives mem_addr=5'h05; then load_acc+sel_bus with mem_rdata=8'h7F -> acc=8'h7F, zero=0, carry=0.
3. acc=8'hF0; load_acc+sel_alu+pass_add with mem_rdata=8'h20 -> acc=8'h10, carry=1. Then add 8'hF0 -> acc=8'h00, zero=1, carry=1.
4. acc=8'h5A; mem_write+ir_on_adr with IR operand 5'h1F -> mem_we=1, mem_wdata=8'h5A, mem_addr=5'h1F; acc unchanged.
5. pc=5'h1F, inc_pc -> pc=0. Next, IR operand 5'h0C with ld_pc alone -> pc=5'h0C. Next, clr_pc+inc_pc -> pc=0.
6. Assert pc_on_adr+ir_on_adr -> ctrl_error=1 and stays 1 for 10 legal cycles. load_acc with sel_alu=sel_bus=1 -> acc holds. Sync reset -> ctrl_error=0, acc=0, instr_count=0.
